// File: rtl/full_adder.sv
// One-bit full adder built from discrete gates; the single arithmetic slice
// that the serial adder reuses every cycle.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_in_i,
  output logic sum_o,
  output logic carry_out_o
);
  logic ab_xor;
  logic ab_and;
  logic prop_and;

  xor_gate u_xor_ab  (.a_i(a_i),    .b_i(b_i),        .y_o(ab_xor));
  xor_gate u_xor_sum (.a_i(ab_xor), .b_i(carry_in_i), .y_o(sum_o));
  and_gate u_and_gen (.a_i(a_i),    .b_i(b_i),        .y_o(ab_and));
  and_gate u_and_prp (.a_i(ab_xor), .b_i(carry_in_i), .y_o(prop_and));
  or_gate  u_or_cout (.a_i(ab_and), .b_i(prop_and),   .y_o(carry_out_o));
endmodule

// File: rtl/serial_adder_gates.sv
// Primitive two-input gates used to build the bit-slice full adder.
module xor_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ^ b_i;
endmodule

module and_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

module or_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder slice processes one bit pair per
// clock, LSB first, with a start/busy/done handshake and a registered result.
//
// state    | meaning
// ST_IDLE  | waiting for start_i, result held
// ST_SHIFT | one bit pair added per clock
// ST_DONE  | result newly valid (done_o); start_i here chains back-to-back
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_full_adder (
    .a_i        (a_sh_q[0]),
    .b_i        (b_sh_q[0]),
    .carry_in_i (carry_q),
    .sum_o      (fa_sum),
    .carry_out_o(fa_cout)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = carry_in_i;
          count_d = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_cout;
        count_d = count_q + 1'b1;
        if (count_q == LAST_BIT) begin
          sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy_o      = (state_q == ST_SHIFT);
  assign done_o      = (state_q == ST_DONE);
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus hand-written
// sequences for ignored start, back-to-back, mid-op reset and result hold.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         carry_in_i = 1'b0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         carry_out_o;

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .carry_in_i (carry_in_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sum_o      (sum_o),
    .carry_out_o(carry_out_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a one-cycle start pulse; returns at the first negedge in SHIFT.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk_i);
    a_i = a; b_i = b; carry_in_i = cin; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // lat=1 at the first SHIFT negedge; done expected at lat=9.
  task automatic wait_done(output int busy_cycles, output int lat);
    busy_cycles = 0;
    lat = 1;
    while (!done_o && lat < 30) begin
      if (busy_o) busy_cycles++;
      @(negedge clk_i);
      lat++;
    end
  endtask

  initial begin
    int bc, lat, dcnt, first_done;
    logic [W-1:0] s_at_done;
    logic         c_at_done;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    // Reset, then idle with start low for 20 cycles
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
    check("idle_sum", sum_o, 0);
    check("idle_cout", carry_out_o, 0);

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(bc, lat);
      check($sformatf("v%0d_latency", i), lat, 9);
      check($sformatf("v%0d_busy_cycles", i), bc, 8);
      check($sformatf("v%0d_sum", i), sum_o, vecs[i].s);
      check($sformatf("v%0d_cout", i), carry_out_o, vecs[i].c);
      @(negedge clk_i);
      check($sformatf("v%0d_done_pulse", i), done_o, 0);
    end

    // start_i during SHIFT must be ignored
    start_op(8'h10, 8'h20, 1'b0);
    bc = 0; dcnt = 0; first_done = 0; s_at_done = '0; c_at_done = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin a_i = 8'h01; b_i = 8'h01; start_i = 1'b1; end
      if (k == 4) start_i = 1'b0;
      if (busy_o) bc++;
      if (done_o) begin
        dcnt++;
        if (first_done == 0) begin
          first_done = k; s_at_done = sum_o; c_at_done = carry_out_o;
        end
      end
      @(negedge clk_i);
    end
    check("ign_busy_cycles", bc, 8);
    check("ign_done_count", dcnt, 1);
    check("ign_done_pos", first_done, 9);
    check("ign_sum", s_at_done, 8'h30);
    check("ign_cout", c_at_done, 0);

    // Back-to-back: start held during the DONE cycle
    start_op(8'h35, 8'h4A, 1'b0);
    wait_done(bc, lat);
    check("b2b_first_sum", sum_o, 8'h7F);
    a_i = 8'h0F; b_i = 8'h01; carry_in_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("b2b_no_idle", busy_o, 1);
    check("b2b_sum_held", sum_o, 8'h7F);
    wait_done(bc, lat);
    check("b2b_gap", lat, 9);
    check("b2b_sum", sum_o, 8'h10);
    check("b2b_cout", carry_out_o, 0);

    // Reset in SHIFT cycle 4 aborts the operation
    start_op(8'h80, 8'h80, 1'b0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_busy", busy_o, 0);
    check("rst_sum", sum_o, 0);
    check("rst_cout", carry_out_o, 0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_o) dcnt++;
      @(negedge clk_i);
    end
    check("rst_no_done", dcnt, 0);
    start_op(8'h80, 8'h81, 1'b0);
    wait_done(bc, lat);
    check("rst_fresh_lat", lat, 9);
    check("rst_fresh_sum", sum_o, 8'h01);
    check("rst_fresh_cout", carry_out_o, 1);

    // Operand inputs toggling in IDLE leave the result untouched
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      a_i = W'($urandom); b_i = W'($urandom); carry_in_i = ~carry_in_i;
    end
    @(negedge clk_i);
    check("hold_busy", busy_o, 0);
    check("hold_sum", sum_o, 8'h01);
    check("hold_cout", carry_out_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder with a start/busy/done handshake.
- Latches two operands and a carry-in, then feeds one full_adder one bit pair per clock, LSB first, registering the carry between cycles.
- Presents the WIDTH-bit sum and final carry-out as a registered result.
- Low-area alternative to a ripple-carry chain for tile-constrained designs.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 2).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- start_i  input  1  request a new addition; sampled only in IDLE or DONE.
- a_i  input  WIDTH  operand A; captured on the accepting edge.
- b_i  input  WIDTH  operand B; captured on the accepting edge.
- carry_in_i  input  1  initial carry; captured on the accepting edge.
- busy_o  output  1  high while bits are being processed (SHIFT).
- done_o  output  1  one-cycle pulse: result valid and newly updated.
- sum_o  output  WIDTH  registered sum of last completed operation.
- carry_out_o  output  1  registered carry-out of last completed operation.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE; bit counter=0; carry register=0; shift registers=0.
  - busy_o=0, done_o=0, sum_o=0, carry_out_o=0.
  - Reset dominates start_i.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start_i=1 -> load a_sh=a_i, b_sh=b_i, carry_q=carry_in_i, count=0; next SHIFT. Otherwise stay.
  - SHIFT: each edge applies a_sh[0], b_sh[0], carry_q to full_adder.
    - Sum bit shifts into s_sh from the MSB side.
    - a_sh and b_sh shift right; carry_q <= full_adder carry_out_o; count++.
    - On the edge processing count=WIDTH-1: sum_o <= completed s_sh, carry_out_o <= final carry, next DONE.
  - DONE: done_o=1 for this one cycle.
    - start_i=1 -> load new operands as in IDLE, next SHIFT (back-to-back).
    - Otherwise next IDLE.
- Latency: start accepted at edge E -> done_o high in the cycle following edge E+WIDTH. Throughput: one result per WIDTH+1 cycles.
- busy_o = (state==SHIFT), decoded from registered state. done_o = (state==DONE).
- start_i while in SHIFT is ignored; no queuing, no error flag.
- sum_o and carry_out_o:
  - Hold the previous result through SHIFT.
  - Change only on the completing edge.
  - Stable in IDLE until the next completion.
- a_i, b_i and carry_in_i may change freely after acceptance.
- Reset mid-SHIFT aborts the operation: no done_o pulse, outputs cleared to 0.
- Arithmetic: {carry_out_o, sum_o} == a + b + carry_in, modulo 2^(WIDTH+1); unsigned, no overflow flag.
- Counter width: $clog2(WIDTH).

Decomposition:
- No shared package.
- State encodings are localparams inside the module (2-bit binary).
- One sub-module instance: full_adder (existing, built from xor_gate/and_gate/or_gate), driven from a_sh[0], b_sh[0], carry_q.
- No other sub-modules; shift registers, counter and FSM are local.

Test Plan (WIDTH=8):
- Basic add: a=0x35, b=0x4A, cin=0, start 1 cycle -> busy_o for 8 cycles; done_o one cycle 8 edges after start edge; sum_o=0x7F, carry_out_o=0.
- Full ripple: a=0xFF, b=0x01, cin=0 -> sum_o=0x00, carry_out_o=1. Then a=0xFF, b=0xFF, cin=1 -> sum_o=0xFF, carry_out_o=1.
- Ignored start: start a=0x10, b=0x20; assert start_i with a=0x01, b=0x01 on SHIFT cycle 3 -> result 0x30, carry 0; exactly one done_o; busy_o never drops early.
- Back-to-back: hold start_i=1 with a=0x0F, b=0x01 during the DONE cycle of a prior op -> no IDLE cycle; second done_o 9 cycles after the first; sum_o=0x10.
- Reset mid-op: start a=0x80, b=0x80; assert rst_i on SHIFT cycle 4 -> next cycle busy_o=0, sum_o=0x00, carry_out_o=0; no done_o; fresh start afterwards completes correctly.
- Hold/reset values: after reset with start_i=0 for 20 cycles -> all outputs 0. After a completion, operand inputs toggling in IDLE leave sum_o/carry_out_o unchanged.
